// File: rtl/mealy2_steer.sv
// rtl/mealy2_steer.sv - shortest-path X/Y steering controller with shadow Mealy state and Z check (MEALY2_STEER_ZCHECK_EN)
module mealy2_steer #(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [1:0]       target,
    input  logic             Z,
    output logic             X,
    output logic             Y,
    output logic             busy,
    output logic             done,
    output logic [1:0]       steps,
    output logic [1:0]       model_state,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_00 = 2'b00,
        ST_01 = 2'b01,
        ST_10 = 2'b10,
        ST_11 = 2'b11
    } mstate_t;

    mstate_t    model_q, model_d;
    logic [1:0] target_q, target_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] steps_q, steps_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] xy;
    logic [1:0] model_next;

    // Transition function of the driven Mealy machine
    function automatic logic [1:0] next_state(input mstate_t ps, input logic [1:0] in);
        logic [1:0] ns;
        ns = 2'b00;
        case (ps)
            ST_00: ns = in;
            ST_01: begin
                case (in)
                    2'b00:   ns = 2'b01;
                    2'b01:   ns = 2'b10;
                    2'b10:   ns = 2'b10;
                    default: ns = 2'b00;
                endcase
            end
            ST_10: ns = (in == 2'b11) ? 2'b10 : 2'b11;
            default: ns = (in == 2'b11) ? 2'b01 : 2'b00;
        endcase
        return ns;
    endfunction

    // X/Y selection: hold policy when idle, shortest-path edge toward target when busy
    always_comb begin
        xy = 2'b00;
        if (!busy_q) begin
            if (model_q == ST_10) begin
                xy = 2'b11;
            end
        end else begin
            case (model_q)
                ST_00:   xy = target_q;
                ST_01:   xy = (target_q == 2'b10) ? 2'b01 : 2'b11;
                ST_10:   xy = 2'b00;
                default: xy = (target_q == 2'b01) ? 2'b11 : 2'b00;
            endcase
        end
    end

    assign X           = xy[1];
    assign Y           = xy[0];
    assign model_next  = next_state(model_q, xy);
    assign busy        = busy_q;
    assign done        = done_q;
    assign steps       = steps_q;
    assign model_state = model_q;

    // Handshake sequencer: accept, count transitions, finish when the next state is the target
    always_comb begin
        model_d  = mstate_t'(model_next);
        target_d = target_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        steps_d  = steps_q;
        cnt_d    = cnt_q;
        if (busy_q) begin
            cnt_d = cnt_q + 2'd1;
            if (model_next == target_q) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                steps_d = cnt_q + 2'd1;
            end
        end else if (req) begin
            target_d = target;
            cnt_d    = 2'd0;
            if (model_next == target) begin
                done_d  = 1'b1;
                steps_d = 2'd0;
            end else begin
                busy_d = 1'b1;
            end
        end
    end

    // Shadow state and sequencer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_q  <= ST_00;
            target_q <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            steps_q  <= 2'b00;
            cnt_q    <= 2'b00;
        end else begin
            model_q  <= model_d;
            target_q <= target_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            steps_q  <= steps_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef MEALY2_STEER_ZCHECK_EN
    logic             z_exp;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_q, err_d;

    // Expected Z for the current state and inputs
    always_comb begin
        z_exp = 1'b0;
        case (model_q)
            ST_00:   z_exp = X;
            ST_01:   z_exp = ~X;
            ST_10:   z_exp = ~Y;
            default: z_exp = Y;
        endcase
    end

    // Sticky mismatch flag and saturating error count
    always_comb begin
        mismatch_d = mismatch_q;
        err_d      = err_q;
        if (Z != z_exp) begin
            mismatch_d = 1'b1;
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    // Z check registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;
`else
    logic unused_z;
    assign unused_z = Z;
    assign mismatch = 1'b0;
    assign err_cnt  = '0;
`endif

endmodule
